// File: rtl/free_list.sv
// Circular FIFO of free physical-register tags between retire and dispatch.
// Hands out up to two tags per cycle and reclaims up to two retired Told tags per cycle.
module free_list #(
  parameter int unsigned NUM_PR = 96,
  parameter int unsigned NUM_AR = 32,
  parameter int unsigned DEPTH  = NUM_PR - NUM_AR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] rs_mt_fl_dispatch_num,
  input  logic [1:0] fl_retire_num,
  input  logic [6:0] fl_retire_tag_a,
  input  logic [6:0] fl_retire_tag_b,
  output logic [6:0] fl_pr0,
  output logic [6:0] fl_pr1,
  output logic [1:0] fl_avail,
  output logic [6:0] fl_count,
  output logic       fl_error
);

  localparam int unsigned TW = 7;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [TW-1:0] entry_q [DEPTH];
  logic [TW-1:0] entry_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          error_q, error_d;

  logic [PW-1:0] head1, head2, tail1, tail2;
  logic [SW-1:0] cnt_s, p_s, q_s, p_acc, q_acc;
  logic          pop_ok, push_ok, tag_ok_a, tag_ok_b, tags_ok;

  // Pointer wrap by explicit compare so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign head1 = ptr_inc(head_q);
  assign head2 = ptr_inc(head1);
  assign tail1 = ptr_inc(tail_q);
  assign tail2 = ptr_inc(tail1);

  always_comb begin
    entry_d  = entry_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    error_d  = error_q;
    cnt_s    = SW'(count_q);
    p_s      = SW'(rs_mt_fl_dispatch_num);
    q_s      = SW'(fl_retire_num);
    tag_ok_a = (fl_retire_tag_a >= TW'(NUM_AR)) && (fl_retire_tag_a < TW'(NUM_PR));
    tag_ok_b = (fl_retire_tag_b >= TW'(NUM_AR)) && (fl_retire_tag_b < TW'(NUM_PR));
    tags_ok  = (fl_retire_num == 2'd0) ||
               (tag_ok_a && ((fl_retire_num != 2'd2) || tag_ok_b));

    // Pop judged on start-of-cycle count; push judged on the post-pop occupancy.
    pop_ok  = (rs_mt_fl_dispatch_num != 2'd3) && (p_s <= cnt_s);
    p_acc   = pop_ok ? p_s : '0;
    push_ok = (fl_retire_num != 2'd3) && tags_ok &&
              ((cnt_s - p_acc + q_s) <= SW'(DEPTH));
    q_acc   = push_ok ? q_s : '0;

    if (p_acc == SW'(1))      head_d = head1;
    else if (p_acc == SW'(2)) head_d = head2;

    if (q_acc != '0)     entry_d[tail_q] = fl_retire_tag_a;
    if (q_acc == SW'(2)) entry_d[tail1]  = fl_retire_tag_b;

    if (q_acc == SW'(1))      tail_d = tail1;
    else if (q_acc == SW'(2)) tail_d = tail2;

    count_d = CW'(cnt_s - p_acc + q_acc);
    error_d = error_q | ~pop_ok | ~push_ok;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= TW'(int'(NUM_AR) + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(DEPTH);
      error_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Tags are presented straight from registered state so dispatch can use them this cycle.
  assign fl_pr0   = (count_q != '0)      ? entry_q[head_q] : 7'h7f;
  assign fl_pr1   = (count_q >= CW'(2))  ? entry_q[head1]  : 7'h7f;
  assign fl_avail = (count_q >= CW'(2))  ? 2'd2 : 2'(count_q);
  assign fl_count = TW'(count_q);
  assign fl_error = error_q;

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: reference queue model plus scoreboard of dispatched tags.
module tb_free_list;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dnum  = '0;
  logic [1:0] rnum  = '0;
  logic [6:0] tag_a = '0;
  logic [6:0] tag_b = '0;
  logic [6:0] fl_pr0, fl_pr1, fl_count;
  logic [1:0] fl_avail;
  logic       fl_error;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] mq[$];
  logic [6:0] exp_q[$];
  bit         merr;

  free_list dut (
    .clock                 (clock),
    .reset                 (reset),
    .rs_mt_fl_dispatch_num (dnum),
    .fl_retire_num         (rnum),
    .fl_retire_tag_a       (tag_a),
    .fl_retire_tag_b       (tag_b),
    .fl_pr0                (fl_pr0),
    .fl_pr1                (fl_pr1),
    .fl_avail              (fl_avail),
    .fl_count              (fl_count),
    .fl_error              (fl_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    mq.delete();
    exp_q.delete();
    for (int i = 0; i < 64; i++) mq.push_back(7'(32 + i));
    merr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, "_count"}, int'(fl_count), sz);
    chk({tag, "_avail"}, int'(fl_avail), (sz >= 2) ? 2 : sz);
    chk({tag, "_err"},   int'(fl_error), int'(merr));
    chk({tag, "_pr0"},   int'(fl_pr0), (sz >= 1) ? int'(mq[0]) : 127);
    chk({tag, "_pr1"},   int'(fl_pr1), (sz >= 2) ? int'(mq[1]) : 127);
  endtask

  // One cycle: drive, score dispatched tags, advance model, clock.
  task automatic step(input logic [1:0] p, input logic [1:0] q,
                      input logic [6:0] a, input logic [6:0] b);
    int  sz, pa;
    bit  pok, qok, tok;
    dnum = p; rnum = q; tag_a = a; tag_b = b;
    sz  = mq.size();
    pok = (p != 2'd3) && (int'(p) <= sz);
    pa  = pok ? int'(p) : 0;
    for (int k = 0; k < pa; k++) exp_q.push_back(mq[k]);
    if (pa >= 1) chk("disp0", int'(fl_pr0), int'(exp_q.pop_front()));
    if (pa == 2) chk("disp1", int'(fl_pr1), int'(exp_q.pop_front()));
    tok = (q == 2'd0) ||
          ((a >= 7'd32 && a <= 7'd95) && (q != 2'd2 || (b >= 7'd32 && b <= 7'd95)));
    qok = (q != 2'd3) && tok && (sz - pa + int'(q) <= 64);
    for (int k = 0; k < pa; k++) void'(mq.pop_front());
    if (qok && q >= 2'd1) mq.push_back(a);
    if (qok && q == 2'd2) mq.push_back(b);
    merr = merr | !pok | !qok;
    @(posedge clock); #1;
    dnum = '0; rnum = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0; dnum = '0; rnum = '0;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    mdl_reset();
  endtask

  initial begin
    do_reset();
    check_state("reset");
    chk("reset_pr0_const", int'(fl_pr0), 32);
    chk("reset_pr1_const", int'(fl_pr1), 33);

    for (int i = 0; i < 3; i++) step(2'd2, 2'd0, '0, '0);
    check_state("pop3x2");
    chk("pop3x2_pr0_const", int'(fl_pr0), 38);

    while (mq.size() > 2) step(2'd2, 2'd0, '0, '0);
    step(2'd1, 2'd0, '0, '0);
    check_state("count1");
    chk("count1_head95", int'(fl_pr0), 95);
    step(2'd2, 2'd0, '0, '0);
    check_state("underflow");
    step(2'd1, 2'd2, 7'd40, 7'd41);
    check_state("popush");
    chk("popush_pr0_const", int'(fl_pr0), 40);

    do_reset();
    for (int i = 0; i < 32; i++) step(2'd2, 2'd2, 7'(95 - 2 * i), 7'(94 - 2 * i));
    check_state("wrap_full");
    for (int i = 0; i < 32; i++) step(2'd2, 2'd0, '0, '0);
    check_state("wrap_empty");
    step(2'd0, 2'd2, 7'd60, 7'd61);
    check_state("push_empty");

    step(2'd0, 2'd1, 7'd10, '0);
    check_state("range_lo");
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           7'($urandom_range(20, 100)), 7'($urandom_range(20, 100)));
      if (i % 10 == 0) check_state("rand");
    end

    do_reset();
    step(2'd0, 2'd1, 7'd50, '0);
    check_state("overflow");
    reset = 1'b0;
    #1;
    mdl_reset();
    check_state("midreset");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check_state("post_midreset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
